keypad_entry: RTL

KEYPAD_ENTRY -- requirements
Module: keypad_entry

---
 rtl/keypad_entry.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/keypad_entry.sv
// Debounced keypad entry buffer: qualifies key codes, acknowledges each press
// once, and maintains a BCD digit buffer with backspace and enter.
// Ports:
//   clock, reset (async, active-high)
//   key_code[3:0]      : 0-9 digit, 10 '*', 11 '#', others = no key
//   clear_entry        : synchronous buffer clear
//   ack_key[31:0]      : bit 0 pulses one cycle per accepted key
//   entry_bcd          : live buffer, newest digit in bits 3:0
//   digit_count[3:0]   : digits held in buffer
//   entry_valid        : one-cycle pulse when entry_value is loaded
//   entry_value        : buffer captured at last accepted '#'
//   entry_error        : one-cycle pulse on overflow or empty enter
module keypad_entry #(
    parameter int STABLE_CYCLES = 4,
    parameter int MAX_DIGITS    = 6
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [3:0]              key_code,
    input  logic                    clear_entry,
    output logic [31:0]             ack_key,
    output logic [4*MAX_DIGITS-1:0] entry_bcd,
    output logic [3:0]              digit_count,
    output logic                    entry_valid,
    output logic [4*MAX_DIGITS-1:0] entry_value,
    output logic                    entry_error
);

    localparam int W  = 4 * MAX_DIGITS;
    localparam int CW = $clog2(STABLE_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        QUAL,
        ACK,
        RELEASE
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     code_q, code_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [CW-1:0]  rel_q, rel_d;
    logic           ack_q, ack_d;
    logic [W-1:0]   bcd_q, bcd_d;
    logic [3:0]     count_q, count_d;
    logic           valid_q, valid_d;
    logic [W-1:0]   value_q, value_d;
    logic           error_q, error_d;
    logic           key_ok;
    logic           act;

    assign key_ok = (key_code <= 4'd11);

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        rel_d   = rel_q;
        ack_d   = 1'b0;
        bcd_d   = bcd_q;
        count_d = count_q;
        valid_d = 1'b0;
        value_d = value_q;
        error_d = 1'b0;
        act     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (key_ok) begin
                    code_d  = key_code;
                    cnt_d   = CW'(1);
                    state_d = QUAL;
                end
            end
            QUAL: begin
                if (key_code == code_q) begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q + CW'(1) == CW'(STABLE_CYCLES)) begin
                        act     = 1'b1;
                        ack_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = ACK;
                    end
                end else begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            ACK: begin
                rel_d   = '0;
                state_d = RELEASE;
            end
            RELEASE: begin
                if (key_ok) begin
                    rel_d = '0;
                end else if (rel_q + CW'(1) == CW'(STABLE_CYCLES)) begin
                    rel_d   = '0;
                    state_d = IDLE;
                end else begin
                    rel_d = rel_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // A clear in the same cycle swallows the action and its pulses,
        // but the handshake above still proceeds.
        if (act && !clear_entry) begin
            unique case (1'b1)
                (code_q <= 4'd9): begin
                    if (count_q < 4'(MAX_DIGITS)) begin
                        bcd_d   = (bcd_q << 4) | W'(code_q);
                        count_d = count_q + 4'd1;
                    end else begin
                        error_d = 1'b1;
                    end
                end
                (code_q == 4'd10): begin
                    if (count_q != 4'd0) begin
                        bcd_d   = bcd_q >> 4;
                        count_d = count_q - 4'd1;
                    end
                end
                default: begin
                    if (count_q != 4'd0) begin
                        value_d = bcd_q;
                        valid_d = 1'b1;
                        bcd_d   = '0;
                        count_d = 4'd0;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            endcase
        end

        if (clear_entry) begin
            bcd_d   = '0;
            count_d = 4'd0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            code_q  <= 4'd0;
            cnt_q   <= '0;
            rel_q   <= '0;
            ack_q   <= 1'b0;
            bcd_q   <= '0;
            count_q <= 4'd0;
            valid_q <= 1'b0;
            value_q <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
            rel_q   <= rel_d;
            ack_q   <= ack_d;
            bcd_q   <= bcd_d;
            count_q <= count_d;
            valid_q <= valid_d;
            value_q <= value_d;
            error_q <= error_d;
        end
    end

    assign ack_key     = {31'd0, ack_q};
    assign entry_bcd   = bcd_q;
    assign digit_count = count_q;
    assign entry_valid = valid_q;
    assign entry_value = value_q;
    assign entry_error = error_q;

endmodule
